// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline front end.
package arm_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Default PC loaded on reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction word placed in the IF/ID register for a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for an instruction fetched while the
// pipeline could not accept it, tagged with the PC it came from.
module fetch_buffer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] instrIn,
  input  logic [XLEN-1:0] pcIn,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  // Capture on load, empty on reset or clear (clear wins over load).
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instrIn;
      pc    <= pcIn;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem request sequencing,
// one-entry holding buffer and the IF/ID pipeline register.
//
// imem handshake: imem_req is held high with imem_addr stable until
// imem_ack is seen; the ack may arrive in the same cycle as the request.
// A request is never withdrawn while waiting, except by reset.
module fetch_stage
  import arm_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            BranchTakenE,
  input  logic [XLEN-1:0] BranchTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCPlus8D,
  output logic            ValidD,
  output logic            FetchBusy,
  output fetch_state_t    FetchStateDbg
);

  fetch_state_t    state, stateNext;
  logic [XLEN-1:0] pcNext;
  logic [XLEN-1:0] drainAddr, drainAddrNext;
  logic [XLEN-1:0] branchTarget;

  logic            bufLoad, bufClear, bufValid;
  logic [XLEN-1:0] bufInstr, bufPc;

  // fetchHit: imem data goes straight to decode; holdRelease: buffer does.
  logic            fetchHit, holdRelease;

  // Redirect targets are always word aligned.
  assign branchTarget = BranchTargetE & ~XLEN'(3);

  assign imem_req      = !rst && (state != HOLD);
  assign imem_addr     = (state == DRAIN) ? drainAddr : PCF;
  assign FetchBusy     = (state == FETCH && imem_req && !imem_ack) || (state == DRAIN);
  assign FetchStateDbg = state;

  fetch_buffer #(.XLEN(XLEN)) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .load    (bufLoad),
    .clear   (bufClear),
    .instrIn (imem_rdata),
    .pcIn    (PCF),
    .instr   (bufInstr),
    .pc      (bufPc),
    .valid   (bufValid)
  );

  // Next-state decode: branch redirect outranks stall in every state.
  always_comb begin
    stateNext     = state;
    pcNext        = PCF;
    drainAddrNext = drainAddr;
    bufLoad       = 1'b0;
    bufClear      = 1'b0;
    fetchHit      = 1'b0;
    holdRelease   = 1'b0;
    unique case (state)
      FETCH: begin
        if (BranchTakenE) begin
          pcNext   = branchTarget;
          bufClear = 1'b1;
          if (!imem_ack) begin
            // Old request still open: remember it so it can be retired.
            drainAddrNext = PCF;
            stateNext     = DRAIN;
          end
        end else if (imem_ack) begin
          if (StallF || FlushD) begin
            bufLoad   = 1'b1;
            stateNext = HOLD;
          end else begin
            fetchHit = 1'b1;
            pcNext   = PCF + XLEN'(4);
          end
        end
      end
      HOLD: begin
        if (BranchTakenE) begin
          pcNext    = branchTarget;
          bufClear  = 1'b1;
          stateNext = FETCH;
        end else if (!StallD && !StallF && bufValid) begin
          holdRelease = 1'b1;
          bufClear    = 1'b1;
          pcNext      = PCF + XLEN'(4);
          stateNext   = FETCH;
        end
      end
      DRAIN: begin
        if (BranchTakenE) pcNext = branchTarget;
        if (imem_ack) stateNext = FETCH;
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // Sequencer state, fetch PC and the stale address being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      PCF       <= RESET_PC;
      drainAddr <= '0;
    end else begin
      state     <= stateNext;
      PCF       <= pcNext;
      drainAddr <= drainAddrNext;
    end
  end

  // IF/ID register: reset > flush > stall > load instruction or bubble.
  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      InstrD   <= XLEN'(NOP_INSTR);
      PCPlus8D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCPlus8D <= PCPlus8D;
      ValidD   <= ValidD;
    end else if (fetchHit) begin
      InstrD   <= imem_rdata;
      PCPlus8D <= PCF + XLEN'(8);
      ValidD   <= 1'b1;
    end else if (holdRelease) begin
      InstrD   <= bufInstr;
      PCPlus8D <= bufPc + XLEN'(8);
      ValidD   <= 1'b1;
    end else begin
      InstrD   <= XLEN'(NOP_INSTR);
      PCPlus8D <= '0;
      ValidD   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle to a transaction-level model.
`timescale 1ns/1ps
module tb_fetch_stage;
  import arm_pkg::*;

  localparam logic [31:0] RDATA_KEY = 32'hE000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic         BranchTakenE = 1'b0;
  logic [31:0]  BranchTargetE = '0;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack = 1'b1;
  logic [31:0]  imem_rdata;
  logic [31:0]  PCF, InstrD, PCPlus8D;
  logic         ValidD, FetchBusy;
  fetch_state_t stateDbg;

  // Memory content is a fixed function of the address.
  assign imem_rdata = imem_addr ^ RDATA_KEY;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .PCF           (PCF),
    .InstrD        (InstrD),
    .PCPlus8D      (PCPlus8D),
    .ValidD        (ValidD),
    .FetchBusy     (FetchBusy),
    .FetchStateDbg (stateDbg)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The pipeline front end as transactions: a PC, at most one parked
  // instruction {instr, pc}, an optional abandoned request waiting for
  // its ack, and the contents of the decode slot.
  logic        modelOn = 1'b0;
  logic [31:0] mPc;
  logic [63:0] exp_q[$];
  logic        mDrain;
  logic [31:0] mDrainAddr;
  logic [31:0] mIdI, mIdP;
  logic        mIdV;

  task automatic model_step();
    logic [31:0] nI, nP, tgt, rd, cur;
    logic        nV;
    logic [63:0] e;
    if (rst) begin
      modelOn    = 1'b1;
      mPc        = 32'h0;
      exp_q.delete();
      mDrain     = 1'b0;
      mDrainAddr = 32'h0;
      mIdI = 32'h0; mIdP = 32'h0; mIdV = 1'b0;
      return;
    end
    if (!modelOn) return;
    nI = 32'h0; nP = 32'h0; nV = 1'b0;
    tgt = {BranchTargetE[31:2], 2'b00};
    cur = mPc;
    rd  = cur ^ RDATA_KEY;
    if (mDrain) begin
      if (BranchTakenE) mPc = tgt;
      if (imem_ack) mDrain = 1'b0;
    end else if (exp_q.size() != 0) begin
      if (BranchTakenE) begin
        exp_q.delete();
        mPc = tgt;
      end else if (!StallF && !StallD) begin
        e = exp_q.pop_front();
        nI = e[63:32]; nP = e[31:0] + 32'd8; nV = 1'b1;
        mPc = cur + 32'd4;
      end
    end else begin
      if (BranchTakenE) begin
        if (!imem_ack) begin
          mDrain = 1'b1;
          mDrainAddr = cur;
        end
        mPc = tgt;
      end else if (imem_ack) begin
        if (StallF || FlushD) exp_q.push_back({rd, cur});
        else begin
          nI = rd; nP = cur + 32'd8; nV = 1'b1;
          mPc = cur + 32'd4;
        end
      end
    end
    if (FlushD) begin
      mIdI = 32'h0; mIdP = 32'h0; mIdV = 1'b0;
    end else if (!StallD) begin
      mIdI = nI; mIdP = nP; mIdV = nV;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    logic expReq;
    forever begin
      @(negedge clk);
      if (modelOn) begin
        expReq = !rst && (mDrain || exp_q.size() == 0);
        chk("imem_req", {31'b0, imem_req}, {31'b0, expReq});
        if (expReq) chk("imem_addr", imem_addr, mDrain ? mDrainAddr : mPc);
        chk("PCF", PCF, mPc);
        chk("ValidD", {31'b0, ValidD}, {31'b0, mIdV});
        chk("InstrD", InstrD, mIdI);
        if (mIdV) chk("PCPlus8D", PCPlus8D, mIdP);
        chk("FetchBusy", {31'b0, FetchBusy}, {31'b0, mDrain || (expReq && !imem_ack)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic sf, input logic sd, input logic fl,
                        input logic br, input logic [31:0] tg, input logic ack);
    StallF = sf; StallD = sd; FlushD = fl;
    BranchTakenE = br; BranchTargetE = tg; imem_ack = ack;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mode;
    // Reset with zero-wait memory.
    set_in(0, 0, 0, 0, 32'h0, 1);
    rst = 1'b1;
    cyc();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    cyc();
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_valid", {31'b0, ValidD}, 32'd0);
    chk("rst_instr", InstrD, 32'h0);

    // Zero-wait streaming.
    rst = 1'b0;
    cyc();
    chk("s0_instr", InstrD, 32'hE000_0000);
    chk("s0_pc8", PCPlus8D, 32'h8);
    chk("s0_valid", {31'b0, ValidD}, 32'd1);
    chk("s0_pcf", PCF, 32'h4);
    cyc();
    chk("s1_instr", InstrD, 32'hE000_0004);
    chk("s1_pcf", PCF, 32'h8);

    // Stall two cycles at PCF=8.
    set_in(1, 1, 0, 0, 32'h0, 1);
    cyc();
    cyc();
    chk("st_pcf", PCF, 32'h8);
    chk("st_instr", InstrD, 32'hE000_0004);
    chk("st_state", {30'b0, stateDbg}, {30'b0, HOLD});
    chk("st_req", {31'b0, imem_req}, 32'd0);
    set_in(0, 0, 0, 0, 32'h0, 1);
    cyc();
    chk("rel_instr", InstrD, 32'hE000_0008);
    chk("rel_pc8", PCPlus8D, 32'h10);
    chk("rel_pcf", PCF, 32'hC);

    // Two wait states then an ack.
    set_in(0, 0, 0, 0, 32'h0, 0);
    cyc();
    chk("ws_valid", {31'b0, ValidD}, 32'd0);
    chk("ws_busy", {31'b0, FetchBusy}, 32'd1);
    chk("ws_pcf", PCF, 32'hC);
    cyc();
    imem_ack = 1'b1;
    cyc();
    chk("ws_instr", InstrD, 32'hE000_000C);
    chk("ws_pcf2", PCF, 32'h10);

    // Redirect with request outstanding -> drain.
    set_in(0, 0, 1, 1, 32'h100, 0);
    cyc();
    chk("dr_state", {30'b0, stateDbg}, {30'b0, DRAIN});
    chk("dr_addr", imem_addr, 32'h10);
    chk("dr_busy", {31'b0, FetchBusy}, 32'd1);
    chk("dr_pcf", PCF, 32'h100);
    set_in(0, 0, 0, 0, 32'h0, 1);
    cyc();
    chk("dr_valid", {31'b0, ValidD}, 32'd0);
    chk("dr_addr2", imem_addr, 32'h100);
    cyc();
    chk("dr_instr", InstrD, 32'hE000_0100);
    chk("dr_pc8", PCPlus8D, 32'h108);

    // Branch + stall + ack together.
    set_in(0, 0, 1, 1, 32'h20, 1);
    cyc();
    chk("bs_pcf0", PCF, 32'h20);
    set_in(1, 0, 0, 1, 32'h40, 1);
    cyc();
    chk("bs_pcf", PCF, 32'h40);
    chk("bs_state", {30'b0, stateDbg}, {30'b0, FETCH});
    set_in(0, 0, 0, 0, 32'h0, 1);

    // Reset while draining.
    set_in(0, 0, 0, 1, 32'h200, 0);
    cyc();
    chk("rd_state", {30'b0, stateDbg}, {30'b0, DRAIN});
    set_in(0, 0, 0, 0, 32'h0, 1);
    rst = 1'b1;
    #1;
    chk("rd_req", {31'b0, imem_req}, 32'd0);
    cyc();
    chk("rd_pcf", PCF, 32'h0);
    chk("rd_valid", {31'b0, ValidD}, 32'd0);
    rst = 1'b0;

    // Wrap at the top of the address space.
    set_in(0, 0, 1, 1, 32'hFFFF_FFFC, 1);
    cyc();
    chk("wr_pcf0", PCF, 32'hFFFF_FFFC);
    set_in(0, 0, 0, 0, 32'h0, 1);
    cyc();
    chk("wr_instr", InstrD, 32'h1FFF_FFFC);
    chk("wr_pc8", PCPlus8D, 32'h4);
    chk("wr_pcf", PCF, 32'h0);

    // Randomized traffic in three memory-latency modes.
    for (int i = 0; i < 3000; i++) begin
      mode = i / 1000;
      rst = ($urandom_range(0, 299) == 0);
      StallF = ($urandom_range(0, 4) == 0);
      StallD = StallF && ($urandom_range(0, 1) == 1);
      BranchTakenE = ($urandom_range(0, 9) == 0);
      FlushD = BranchTakenE && ($urandom_range(0, 1) == 1);
      BranchTargetE = $urandom();
      case (mode)
        0: imem_ack = 1'b1;
        1: imem_ack = ((i % 3) == 2);
        default: imem_ack = ($urandom_range(0, 2) != 0);
      endcase
      if (mDrain && BranchTakenE) imem_ack = 1'b0;
      cyc();
    end
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
